mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single-port synchronous data/instruction RAM between the CPU (requester 0) and a second bus master such as a loader or DMA engine (requester 1). It sits between the requesters' `mem_cmd`/`mem_addr` interfaces and the RAM. It serialises accesses with a 3-state FSM and rotates priority round-robin after each completed access. Each requester holds its command until it receives a one-cycle `ack`.

## Interface
- `AW`, default 9: address width (matches `mem_addr`).
- `DW`, default 16: data width (matches `mdata`).

Command encoding on all `cmd` ports:
- MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10.
- 2'b11 is treated as MNONE.

Ports:
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `reset`  in  1  : synchronous, active-high reset.
- `cmd0`, `cmd1`  in  2 each  : requester commands.
- `addr0`, `addr1`  in  AW each  : requester addresses.
- `wdata0`, `wdata1`  in  DW each  : requester write data.
- `rdata0`, `rdata1`  out  DW each  : read data; valid only while the matching `ack` is high.
- `ack0`, `ack1`  out  1 each  : one-cycle completion pulse.
- `gnt`  out  2  : one-hot owner during ACCESS and DONE; 2'b00 in IDLE.
- `ram_cmd`  out  2  : command to the RAM.
- `ram_addr`  out  AW  : RAM address.
- `ram_wdata`  out  DW  : RAM write data.
- `ram_rdata`  in  DW  : RAM read data, valid the cycle after the address is presented.

## Operation
FSM states: IDLE, ACCESS, DONE.

IDLE:
- `ram_cmd` = MNONE, `gnt` = 00, acks = 0.
- If any requester has a valid command (MREAD or MWRITE), select the winner:
  - If both are valid, the requester indicated by priority pointer `prio` wins.
  - If only one is valid, it wins regardless of `prio`.
- On the clock edge, latch the winner's index, cmd, addr and wdata, then go to ACCESS.
- With no valid command, stay in IDLE.

ACCESS:
- Drive `ram_cmd`/`ram_addr`/`ram_wdata` from the latched values.
- `gnt` = one-hot of the latched index.
- The RAM performs the write at the end of this cycle, or registers the read address.
- Always go to DONE.

DONE:
- `ram_cmd` = MNONE.
- `ack` of the owner = 1.
- The owner's `rdata` = `ram_rdata`. For writes, `rdata` is don't-care.
- The non-owner `rdata` = 0.
- `prio` becomes the other requester's index.
- Go to IDLE.

Rules:
- Latched values, not live inputs, drive the RAM. Changes to inputs during ACCESS/DONE have no effect on the in-flight access.
- Requesters hold `cmd` until `ack`. A requester must drop or change `cmd` in the cycle after `ack`; otherwise it is re-arbitrated as a new request.
- A withdrawn request (cmd goes to MNONE mid-access) still completes, and `ack` is still issued.
- Both `rdata` outputs are 0 whenever their `ack` is low.
- `ack0` and `ack1` are never high together. `gnt` is never 2'b11.

## Timing
Reset (synchronous): state = IDLE, `prio` = 0 (CPU first), all latches cleared. Outputs after reset:
- `ram_cmd` = MNONE, `ram_addr` = 0, `ram_wdata` = 0.
- `gnt` = 00, acks = 0, `rdata0` = `rdata1` = 0.

Reset during ACCESS or DONE aborts the access:
- No `ack` is issued.
- Outputs take reset values in the following cycle.
- A write presented in the aborted ACCESS cycle may already have been committed by the RAM.

Latency, with the request first seen in IDLE at cycle T:
- ACCESS occurs at T+1.
- `ack` is high at T+2.
- The next arbitration is at T+3.
- Sustained throughput is one access per 3 cycles.

Fairness:
- With both requesters continuously requesting, grants alternate 0,1,0,1…
- A requester waits at most 3 cycles after the other's `ack`.

Simultaneous events:
- A new request arriving in DONE waits until the IDLE cycle.
- Reset has priority over every other event.

## Test plan
- **Reset values:** Assert reset for 2 cycles with cmd0=MREAD pending -> all outputs at reset values; first ACCESS occurs 1 cycle after reset deasserts (gnt=01 at that ACCESS cycle).
- **CPU write then read:** cmd0=MWRITE, addr0=9'h005, wdata0=16'hBEEF; then MREAD 9'h005 ->
  - ram_cmd=MWRITE at T+1 and ack0 at T+2.
  - On the read, rdata0=16'hBEEF while ack0 is high.
- **Simultaneous reads after reset:** cmd0=cmd1=MREAD with prio=0 -> requester 0 is served first (ack0 at T+2); requester 1 is then served (ack1 at T+5).
- **Fairness under contention:** Both requesters hold MREAD continuously with new addresses after each ack for 12 accesses -> the ack sequence strictly alternates, and no ack gap exceeds 6 cycles.
- **Lone requester 1 and input stability:** Only cmd1=MWRITE to 9'h1FF with data 16'h0001, starting while prio=0 -> granted immediately.
  - addr1 is changed during ACCESS, and the RAM still sees 9'h1FF.
  - cmd=2'b11 on either port produces no grant.
- **Reset mid-access:** Assert reset in the ACCESS cycle of a requester-1 read -> no ack1; next cycle gnt=00, ram_cmd=MNONE, prio=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Each access takes IDLE -> ACCESS -> DONE, so one access completes every 3 cycles.
module mem_arbiter #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [1:0]    gnt,
  output logic [1:0]    ram_cmd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          own_q, own_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic valid0, valid1, winner;

  // 2'b11 is not a valid command and never requests the RAM.
  assign valid0 = (cmd0 == MREAD) || (cmd0 == MWRITE);
  assign valid1 = (cmd1 == MREAD) || (cmd1 == MWRITE);
  assign winner = (valid0 && valid1) ? prio_q : valid1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      own_q   <= 1'b0;
      cmd_q   <= MNONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      own_q   <= own_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    own_d   = own_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (valid0 || valid1) begin
          state_d = StAccess;
          own_d   = winner;
          cmd_d   = winner ? cmd1 : cmd0;
          addr_d  = winner ? addr1 : addr0;
          wdata_d = winner ? wdata1 : wdata0;
        end
      end
      StAccess: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        prio_d  = ~own_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // The RAM is driven only from latched values so late input changes cannot disturb it.
  always_comb begin
    ram_cmd   = MNONE;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    gnt       = 2'b00;
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    unique case (state_q)
      StIdle: ;
      StAccess: begin
        ram_cmd = cmd_q;
        gnt     = own_q ? 2'b10 : 2'b01;
      end
      StDone: begin
        gnt = own_q ? 2'b10 : 2'b01;
        if (own_q) begin
          ack1   = 1'b1;
          rdata1 = ram_rdata;
        end else begin
          ack0   = 1'b1;
          rdata0 = ram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
